// File: rtl/box_pkg.sv
// Shared types and constants for the frame-rate bounding-box extractor.
package box_pkg;
  localparam int COORD_W = 11;
  localparam int CNT_W   = 20;
  localparam logic [COORD_W-1:0] BOX_EMPTY_MIN = 11'h7FF;
  localparam logic [COORD_W-1:0] BOX_EMPTY_MAX = '0;

  typedef enum logic [1:0] {S_WAIT, S_ACC, S_LATCH} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } box_t;

  // min > max: the overlay draws nothing for this box
  localparam box_t BOX_EMPTY = '{BOX_EMPTY_MIN, BOX_EMPTY_MAX, BOX_EMPTY_MIN, BOX_EMPTY_MAX};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [4:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-4){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/rgb565_thresh.sv
// Combinational RGB565 colour classifier: strong red, weak green and blue.
module rgb565_thresh #(
  parameter logic [4:0] R_TH = 5'd20,
  parameter logic [5:0] G_TH = 6'd24,
  parameter logic [4:0] B_TH = 5'd12
) (
  input  logic [15:0] data_in,
  input  logic        en,
  output logic        hit
);
  assign hit = en && (data_in[15:11] >= R_TH) && (data_in[10:5] <= G_TH)
                  && (data_in[4:0] <= B_TH);
endmodule

// File: rtl/box_detect.sv
// Bounding-box extractor: threshold, horizontal run filter, min/max tracking,
// publish at every vsync rising edge.
module box_detect
  import box_pkg::*;
#(
  parameter logic [4:0] R_TH    = 5'd20,
  parameter logic [5:0] G_TH    = 6'd24,
  parameter logic [4:0] B_TH    = 5'd12,
  parameter int         RUN_LEN = 4,
  parameter int         MIN_PIX = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [15:0]        data_in,
  input  logic               vs,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic               box_valid,
  output logic               frame_done
);
  localparam logic [3:0]       RUN_L   = 4'(RUN_LEN);
  localparam logic [3:0]       RUN_M1  = 4'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);

  state_t             state, state_nxt;
  logic               hit, hit_s1, vs_d, vs_edge, accept, first;
  logic [COORD_W-1:0] x_s1, y_s1, x_cand;
  logic [3:0]         run, run_inc;
  logic [4:0]         add_n;
  logic [CNT_W-1:0]   wcnt;
  box_t               wbox, box_q;
  logic               valid_q, done_q;

  rgb565_thresh #(.R_TH(R_TH), .G_TH(G_TH), .B_TH(B_TH)) u_thresh (
    .data_in (data_in),
    .en      (en),
    .hit     (hit)
  );

  assign vs_edge = vs & ~vs_d;
  assign run_inc = (run == 4'hF) ? run : run + 4'd1;
  assign first   = (run == RUN_M1);
  assign accept  = hit_s1 && (run_inc >= RUN_L) && (state == S_ACC);
  // First accepted pixel stands for the whole qualifying run behind it
  assign x_cand  = first ? x_s1 - COORD_W'(RUN_LEN - 1) : x_s1;
  assign add_n   = first ? 5'(RUN_LEN) : 5'd1;

  // S1: pixel in the edge cycle is dropped, so the new frame starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_s1 <= 1'b0;
      x_s1   <= '0;
      y_s1   <= '0;
      vs_d   <= 1'b0;
      run    <= '0;
    end else begin
      hit_s1 <= hit & ~vs_edge;
      x_s1   <= x;
      y_s1   <= y;
      vs_d   <= vs;
      run    <= (vs_edge || !hit_s1) ? 4'd0 : run_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  if (vs_edge) state_nxt = S_ACC;
      S_ACC:   if (vs_edge) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_ACC;
      default: state_nxt = S_WAIT;
    endcase
  end

  // Working box; the S1 hit of the edge cycle still lands before S_LATCH reads it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbox <= BOX_EMPTY;
      wcnt <= '0;
    end else if (state == S_LATCH) begin
      wbox <= BOX_EMPTY;
      wcnt <= '0;
    end else if (accept) begin
      if (x_cand < wbox.x_min) wbox.x_min <= x_cand;
      if (x_s1   > wbox.x_max) wbox.x_max <= x_s1;
      if (y_s1   < wbox.y_min) wbox.y_min <= y_s1;
      if (y_s1   > wbox.y_max) wbox.y_max <= y_s1;
      wcnt <= sat_add(wcnt, add_n);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_q   <= BOX_EMPTY;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == S_LATCH);
      if (state == S_LATCH) begin
        valid_q <= (wcnt >= MIN_CNT);
        box_q   <= (wcnt >= MIN_CNT) ? wbox : BOX_EMPTY;
      end
    end
  end

  assign x_min      = box_q.x_min;
  assign x_max      = box_q.x_max;
  assign y_min      = box_q.y_min;
  assign y_max      = box_q.y_max;
  assign box_valid  = valid_q;
  assign frame_done = done_q;
endmodule

// File: doc/box_detect.md
# box_detect

Frame-rate bounding-box extractor that sits upstream of the VGA overlay stage. It classifies each active RGB565 pixel against a colour threshold, rejects isolated hits with a horizontal run filter, and tracks the min/max x and y of accepted pixels. At each vertical-sync rising edge it publishes the box as `x_min/x_max/y_min/y_max`, which feed the overlay's box inputs directly. When no valid object is found it publishes an encoding that draws no box.

## Interface
- `R_TH`, 5'd20: minimum red component (R5) for a hit.
- `G_TH`, 6'd24: maximum green component (G6) for a hit.
- `B_TH`, 5'd12: maximum blue component (B5) for a hit.
- `RUN_LEN`, 4: consecutive hits needed before pixels are accepted; legal range 1..15.
- `MIN_PIX`, 64: minimum accepted-pixel count for a frame's box to be valid.

Ports:
- `clk`, in, 1: pixel clock.
- `rst_n`, in, 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `en`, in, 1: active-video qualifier for `data_in`, `x` and `y`.
- `x`, in, 11: column of the current pixel.
- `y`, in, 11: row of the current pixel.
- `data_in`, in, 16: RGB565 pixel, laid out as R[15:11], G[10:5], B[4:0].
- `vs`, in, 1: vertical sync, active high. Its rising edge marks the frame boundary.
- `x_min`, `x_max`, `y_min`, `y_max`, out, 11 each: published box.
- `box_valid`, out, 1: high while the published box is valid.
- `frame_done`, out, 1: one-cycle pulse in the same cycle the outputs update.

## Operation
- Hit rule: `R5 >= R_TH && G6 <= G_TH && B5 <= B_TH && en`. The hit flag, `x` and `y` are registered once (stage S1).
- Run counter: 4 bits, saturating at 15.
  - Increments on each S1 hit.
  - Clears on an S1 miss, on any S1 cycle with `en` low, and on the `vs` edge.
- Accepting a pixel: a hit is accepted when the run count, including the current hit, is at least `RUN_LEN`.
  - First acceptance in a run: the x candidate for the min comparison is `x - (RUN_LEN-1)`. The pixel count adds `RUN_LEN`.
  - Each later acceptance in the same run: candidate is `x`, count adds 1.
  - The y candidate is always `y`.
- Working registers: `wx_min`, `wx_max`, `wy_min`, `wy_max` (11 bits each) and `wcnt` (20 bits, saturating at 2^20-1). They update only on acceptance.
- FSM states:
  - `S_WAIT`: after reset, accumulation is disabled. Go to `S_ACC` on the first `vs` edge. No publish.
  - `S_ACC`: accumulate. On a `vs` edge go to `S_LATCH`.
  - `S_LATCH`, one cycle:
    - If `wcnt >= MIN_PIX`: register the working box to the outputs and set `box_valid` = 1.
    - Otherwise: outputs get `x_min = y_min = 11'h7FF`, `x_max = y_max = 0`, and `box_valid` = 0. With min greater than max, the overlay draws nothing.
    - Reinitialise working registers: mins to 11'h7FF, maxes to 0, `wcnt` to 0.
    - Return to `S_ACC`.
- Edge detection: `vs` is registered into `vs_d`; the edge is `vs & ~vs_d`.
- Simultaneous events:
  - The `vs` edge has priority. Any hit in the S1 stage in that same cycle is still committed before the publish.
  - An `en` high in the edge cycle is discarded.
- Reset mid-frame discards the partial frame and returns the FSM to `S_WAIT`.

## Timing
- Reset values:
  - `x_min` = `y_min` = 11'h7FF.
  - `x_max` = `y_max` = 0.
  - `box_valid` = 0, `frame_done` = 0.
  - FSM in `S_WAIT`; working registers at their init values; `vs_d` = 0.
- Pixel to working register: 2 cycles (S1 register, then update).
- `vs` rises at cycle k → `S_LATCH` at k+1 → outputs and `frame_done` visible at k+2.
- Outputs are stable for the whole following frame. Only `S_LATCH` changes them.
- Back-to-back `vs` edges 2 cycles apart each produce a publish. The second one publishes an empty (invalid) box.

## Structure
- Package `box_pkg`:
  - State encoding: `S_WAIT`, `S_ACC`, `S_LATCH`.
  - `COORD_W` = 11, `CNT_W` = 20.
  - `BOX_EMPTY_MIN` = 11'h7FF, `BOX_EMPTY_MAX` = 0.
- Sub-module `rgb565_thresh`: combinational classifier taking `data_in`, `en` and the threshold parameters, producing `hit`.
- Everything else lives in `box_detect`.

## Test plan
- Box detection: red block (16'hF800) at x 100..199, y 50..89 on a black background, then a `vs` edge → `x_min`=100, `x_max`=199, `y_min`=50, `y_max`=89, `box_valid`=1, `frame_done` pulses once at edge+2.
- Run filter: isolated red pixels at (10,10) and (500,300), plus the block from the first scenario → box unchanged at 100/199/50/89.
- Empty frame: all-black frame → `box_valid`=0, outputs 7FF/0/7FF/0.
- Minimum pixel count: 63 accepted pixels (RUN_LEN 4) → invalid; 64 accepted pixels → valid.
- Reset mid-frame: `rst_n` pulses low mid-frame → outputs at reset values immediately; the first `vs` edge afterwards publishes nothing (`S_WAIT`); the second `vs` edge publishes.
- Run boundary and blanking: a run of exactly 4 hits at x 300..303 (row repeated 20 rows) → `x_min`=300, `x_max`=303. A run split by an `en`-low gap does not accumulate across the gap.
